// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   In-order instruction buffer between the I-cache return path and the
//   rename/dispatch front end. Fetch packets of up to FETCH_WIDTH
//   instructions are compacted into a circular buffer. The oldest
//   instructions, up to ISSUE_WIDTH_MAX of them, are presented each cycle
//   on the ID-to-rename lanes. Every valid lane is consumed at the next edge.
//
// Ports
//   clk            core clock
//   rst            asynchronous reset, active low
//   fetch_val      fetch packet present
//   fetch_cnt      number of valid packet lanes (lanes 0..fetch_cnt-1)
//   fetch_pc       PC of packet lane 0; lane i sits at fetch_pc + 4*i
//   fetch_instr    packet instructions
//   fetch_rdy      buffer can take a full packet this cycle (registered)
//   dispatch_stall back end cannot rename (rob_full | rs_full)
//   flush          drop every buffered and incoming instruction
//   instr_val_id   per-lane valid, contiguous from lane 0
//   instr_id       per-lane instruction (0 when the lane is invalid)
//   pc_id          per-lane PC (0 when the lane is invalid)
//   iq_count       current occupancy
module instr_fetch_queue #(
    parameter int ISSUE_WIDTH_MAX = 2,
    parameter int FETCH_WIDTH     = 4,
    parameter int IQ_DEPTH        = 16,
    parameter int DATA_LEN        = 32,
    parameter int ADDR_LEN        = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          fetch_val,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]              fetch_cnt,
    input  logic [ADDR_LEN-1:0]                           fetch_pc,
    input  logic [FETCH_WIDTH-1:0][DATA_LEN-1:0]          fetch_instr,
    output logic                                          fetch_rdy,
    input  logic                                          dispatch_stall,
    input  logic                                          flush,
    output logic [ISSUE_WIDTH_MAX-1:0]                    instr_val_id,
    output logic [ISSUE_WIDTH_MAX-1:0][DATA_LEN-1:0]      instr_id,
    output logic [ISSUE_WIDTH_MAX-1:0][ADDR_LEN-1:0]      pc_id,
    output logic [$clog2(IQ_DEPTH+1)-1:0]                 iq_count
);

    localparam int PTR_W  = $clog2(IQ_DEPTH);
    localparam int CNT_W  = $clog2(IQ_DEPTH + 1);
    localparam int FCNT_W = $clog2(FETCH_WIDTH + 1);

    localparam logic [CNT_W-1:0] ISSUE_CNT = CNT_W'(ISSUE_WIDTH_MAX);
    // Highest occupancy that still leaves room for a full packet.
    localparam logic [CNT_W-1:0] RDY_MAX   = CNT_W'(IQ_DEPTH - FETCH_WIDTH);

    logic [DATA_LEN-1:0] instr_mem [IQ_DEPTH];
    logic [ADDR_LEN-1:0] pc_mem    [IQ_DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             rdy_q;

    logic             push;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    logic [CNT_W-1:0] count_next;

    // Instructions available to the rename lanes, saturated at the lane count.
    function automatic logic [CNT_W-1:0] sat_issue(input logic [CNT_W-1:0] cnt);
        if (cnt > ISSUE_CNT) begin
            return ISSUE_CNT;
        end
        return cnt;
    endfunction

    // Dispatch lanes: driven purely from registered state plus stall/flush,
    // so a freshly pushed instruction is first visible one cycle later.
    always_comb begin
        pop_n        = (dispatch_stall || flush) ? '0 : sat_issue(count_q);
        instr_val_id = '0;
        instr_id     = '0;
        pc_id        = '0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            if (CNT_W'(i) < pop_n) begin
                instr_val_id[i] = 1'b1;
                instr_id[i]     = instr_mem[head_q + PTR_W'(i)];
                pc_id[i]        = pc_mem[head_q + PTR_W'(i)];
            end
        end
    end

    always_comb begin
        push       = fetch_val && rdy_q && !flush && (fetch_cnt != '0);
        push_n     = push ? CNT_W'(fetch_cnt) : '0;
        count_next = flush ? '0 : (count_q + push_n - pop_n);
    end

    // Control state: pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                head_q <= head_q + PTR_W'(pop_n);
                if (push) begin
                    tail_q <= tail_q + PTR_W'(fetch_cnt);
                end
            end
            count_q <= count_next;
            rdy_q   <= (count_next <= RDY_MAX);
        end
    end

    // Entry storage: written from the pre-pop tail, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (FCNT_W'(i) < fetch_cnt) begin
                    instr_mem[tail_q + PTR_W'(i)] <= fetch_instr[i];
                    pc_mem[tail_q + PTR_W'(i)]    <= fetch_pc + ADDR_LEN'(4 * i);
                end
            end
        end
    end

    assign fetch_rdy = rdy_q;
    assign iq_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int IW = 2;
    localparam int FW = 4;
    localparam int D  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fetch_val = 1'b0;
    logic [2:0]       fetch_cnt = '0;
    logic [31:0]      fetch_pc = '0;
    logic [3:0][31:0] fetch_instr = '0;
    logic             fetch_rdy;
    logic             dispatch_stall = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       instr_val_id;
    logic [1:0][31:0] instr_id;
    logic [1:0][31:0] pc_id;
    logic [4:0]       iq_count;

    instr_fetch_queue #(
        .ISSUE_WIDTH_MAX(IW), .FETCH_WIDTH(FW), .IQ_DEPTH(D), .DATA_LEN(32), .ADDR_LEN(32)
    ) dut (
        .clk(clk), .rst(rst), .fetch_val(fetch_val), .fetch_cnt(fetch_cnt),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_rdy(fetch_rdy),
        .dispatch_stall(dispatch_stall), .flush(flush), .instr_val_id(instr_val_id),
        .instr_id(instr_id), .pc_id(pc_id), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {instr, pc} plus the ready rule.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   mrdy = 1'b0;

    function automatic int n_out();
        if (dispatch_stall || flush) return 0;
        return (mq.size() < IW) ? mq.size() : IW;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mrdy = 1'b0;
        end else begin
            int n;
            n = n_out();
            if (flush) begin
                mq.delete();
            end else begin
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                if (fetch_val && mrdy && fetch_cnt != 0)
                    for (int i = 0; i < int'(fetch_cnt); i++)
                        mq.push_back('{fetch_instr[i], fetch_pc + 32'(4 * i)});
            end
            mrdy = (D - mq.size()) >= FW;
        end
    end

    always @(posedge clk) begin
        if (rst && fetch_val)
            assert (fetch_cnt <= FW) else $error("illegal fetch_cnt %0d", fetch_cnt);
    end

    // Program-order scoreboard for the streaming phase.
    bit seq_on = 1'b0;
    int seq_pc = 0;

    always @(negedge clk) begin
        int n;
        logic [31:0] ei, ep;
        n = n_out();
        check("fetch_rdy", fetch_rdy, mrdy);
        check("iq_count", iq_count, mq.size());
        check("count_bound", iq_count <= D, 1);
        check("instr_val_id", instr_val_id, (1 << n) - 1);
        for (int i = 0; i < IW; i++) begin
            ei = (i < n) ? mq[i].instr : 32'h0;
            ep = (i < n) ? mq[i].pc : 32'h0;
            check($sformatf("instr_id[%0d]", i), instr_id[i], ei);
            check($sformatf("pc_id[%0d]", i), pc_id[i], ep);
        end
        if (seq_on) begin
            for (int i = 0; i < IW; i++) begin
                if (instr_val_id[i]) begin
                    check("seq_pc", pc_id[i], seq_pc);
                    check("seq_instr", instr_id[i], 32'hC000_0000 + 32'(seq_pc / 4));
                    seq_pc += 4;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic v, input logic [2:0] c, input logic [31:0] pc,
                           input logic [31:0] base);
        fetch_val = v;
        fetch_cnt = c;
        fetch_pc  = pc;
        for (int i = 0; i < FW; i++) fetch_instr[i] = base + 32'(i);
    endtask

    initial begin
        int exp_cnt [5] = '{4, 8, 12, 16, 16};
        bit exp_rdy [5] = '{1, 1, 1, 0, 0};
        logic [31:0] pc;
        logic took;
        int k, c, guard;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", fetch_rdy, 0);
        check("rst_cnt", iq_count, 0);
        check("rst_val", instr_val_id, 0);
        rst = 1'b1;
        #1;
        check("rdy_before_edge", fetch_rdy, 0);
        cyc(); #1;
        check("rdy_after_edge", fetch_rdy, 1);
        check("idle_val", instr_val_id, 0);

        // Single full packet
        set_pkt(1, 4, 32'h100, 32'hA000_0000);
        cyc(); set_pkt(0, 0, 0, 0); #1;
        check("p1_val", instr_val_id, 2'b11);
        check("p1_i0", instr_id[0], 32'hA000_0000);
        check("p1_pc0", pc_id[0], 32'h100);
        check("p1_i1", instr_id[1], 32'hA000_0001);
        check("p1_pc1", pc_id[1], 32'h104);
        check("p1_cnt", iq_count, 4);
        cyc(); #1;
        check("p2_i0", instr_id[0], 32'hA000_0002);
        check("p2_pc0", pc_id[0], 32'h108);
        check("p2_i1", instr_id[1], 32'hA000_0003);
        check("p2_pc1", pc_id[1], 32'h10C);
        cyc(); #1;
        check("p3_val", instr_val_id, 0);
        check("p3_cnt", iq_count, 0);

        // Partial packet
        set_pkt(1, 3, 32'h200, 32'hB000_0000);
        cyc(); set_pkt(0, 0, 0, 0); #1;
        check("part_val1", instr_val_id, 2'b11);
        check("part_pc0", pc_id[0], 32'h200);
        check("part_pc1", pc_id[1], 32'h204);
        cyc(); #1;
        check("part_val2", instr_val_id, 2'b01);
        check("part_pc0b", pc_id[0], 32'h208);
        check("part_i1_zero", instr_id[1], 0);
        check("part_pc1_zero", pc_id[1], 0);
        cyc(); #1;
        check("part_empty", iq_count, 0);

        // Back-pressure: fill while stalled, then drain in order
        dispatch_stall = 1'b1;
        pc = 32'h300;
        for (int i = 0; i < 5; i++) begin
            set_pkt(1, 4, pc, 32'hD000_0000 + (pc >> 2));
            took = fetch_rdy;
            cyc();
            if (took) pc += 16;
            #1;
            check("fill_cnt", iq_count, exp_cnt[i]);
            check("fill_rdy", fetch_rdy, exp_rdy[i]);
        end
        dispatch_stall = 1'b0;
        fetch_val = 1'b0;
        #1;
        check("drain_val", instr_val_id, 2'b11);
        check("drain_pc0", pc_id[0], 32'h300);
        check("drain_pc1", pc_id[1], 32'h304);
        for (int d = 0; d < 8; d++) begin
            cyc(); #1;
            check("drain_cnt", iq_count, 14 - 2 * d);
            check("drain_rdy", fetch_rdy, d >= 1);
            if (d < 7) check("drain_lane_pc", pc_id[0], 32'h300 + 32'(8 * (d + 1)));
        end

        // Asynchronous reset mid-operation
        dispatch_stall = 1'b1;
        set_pkt(1, 4, 32'h600, 32'h6000_0000);
        cyc(); set_pkt(0, 0, 0, 0); #2;
        dispatch_stall = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_cnt", iq_count, 0);
        check("midrst_val", instr_val_id, 0);
        check("midrst_rdy", fetch_rdy, 0);
        cyc(); rst = 1'b1;
        cyc(); #1;
        check("postrst_rdy", fetch_rdy, 1);

        // Streaming across the pointer wrap with random stalls
        seq_pc = 0;
        seq_on = 1'b1;
        k = 0;
        guard = 0;
        while (k < 40 && guard < 300) begin
            c = (40 - k < 4) ? 40 - k : 4;
            dispatch_stall = 1'($urandom_range(0, 1));
            set_pkt(1, 3'(c), 32'(k * 4), 32'hC000_0000 + 32'(k));
            took = fetch_rdy;
            cyc();
            if (took) k += c;
            guard++;
        end
        check("stream_push_timeout", guard < 300, 1);
        fetch_val = 1'b0;
        dispatch_stall = 1'b0;
        guard = 0;
        while (iq_count != 0 && guard < 50) begin
            cyc();
            guard++;
        end
        check("stream_drain_timeout", guard < 50, 1);
        @(negedge clk);
        seq_on = 1'b0;
        check("stream_total_pc", seq_pc, 160);
        cyc();

        // Flush with a packet offered in the same cycle
        dispatch_stall = 1'b1;
        set_pkt(1, 4, 32'h700, 32'hE000_0000);
        cyc(); set_pkt(1, 4, 32'h710, 32'hE000_0004);
        cyc(); set_pkt(1, 2, 32'h720, 32'hE000_0008);
        cyc();
        flush = 1'b1;
        dispatch_stall = 1'b0;
        set_pkt(1, 4, 32'h500, 32'h5000_0000);
        #1;
        check("flush_pre_cnt", iq_count, 10);
        check("flush_val", instr_val_id, 0);
        cyc();
        flush = 1'b0;
        fetch_val = 1'b0;
        #1;
        check("flush_cnt", iq_count, 0);
        check("flush_rdy", fetch_rdy, 1);
        set_pkt(1, 2, 32'h400, 32'hF000_0000);
        cyc(); set_pkt(0, 0, 0, 0); #1;
        check("post_flush_val", instr_val_id, 2'b11);
        check("post_flush_pc0", pc_id[0], 32'h400);
        check("post_flush_i0", instr_id[0], 32'hF000_0000);

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- In-order instruction buffer that sits between fetch (I-cache return) and the rename/dispatch front end of blaze_core_top.
- Drives the instr_val_id / instr_id lanes that RAT, RS and ROB consume. It is the transmit end of the ID-to-rename interface.
- Accepts fetch packets of up to FETCH_WIDTH instructions and compacts them into a circular buffer.
- Releases up to ISSUE_WIDTH_MAX oldest instructions per cycle, honours the back-end stall (rob_full | rs_full) and supports a single-cycle flush.

Parameters:
- ISSUE_WIDTH_MAX, 2, rename lanes driven per cycle.
- FETCH_WIDTH, 4, instructions per fetch packet.
- IQ_DEPTH, 16, buffer entries. Must be a power of 2 and >= FETCH_WIDTH + ISSUE_WIDTH_MAX.
- DATA_LEN, 32, instruction width.
- ADDR_LEN, 32, PC width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- fetch_val  in  1  fetch packet present.
- fetch_cnt  in  $clog2(FETCH_WIDTH+1)  number of valid instructions in the packet. Valid instructions occupy lanes 0..fetch_cnt-1.
- fetch_pc  in  ADDR_LEN  PC of fetch lane 0.
- fetch_instr  in  FETCH_WIDTH x DATA_LEN  packet instructions.
- fetch_rdy  out  1  buffer can accept a full packet this cycle.
- dispatch_stall  in  1  back end cannot rename (rob_full | rs_full).
- flush  in  1  discard all buffered instructions.
- instr_val_id  out  ISSUE_WIDTH_MAX  per-lane valid. Always contiguous from lane 0.
- instr_id  out  ISSUE_WIDTH_MAX x DATA_LEN  per-lane instruction.
- pc_id  out  ISSUE_WIDTH_MAX x ADDR_LEN  per-lane PC.
- iq_count  out  $clog2(IQ_DEPTH+1)  current occupancy.

Behaviour:
- State:
  - Storage: entry array of {instr, pc}.
  - Pointers: head_q and tail_q, each $clog2(IQ_DEPTH) bits, wrapping modulo IQ_DEPTH.
  - Occupancy: count_q, 0..IQ_DEPTH.
  - Ready flag: rdy_q.
- Reset (rst=0, async): head_q=0, tail_q=0, count_q=0, rdy_q=0. Entry contents are don't-care.
- Outputs during reset: fetch_rdy=0, instr_val_id=0, instr_id=0, pc_id=0, iq_count=0.
- fetch_rdy = rdy_q. rdy_q is registered: rdy_q <= (IQ_DEPTH - count_next >= FETCH_WIDTH). It therefore rises at the first clk edge after rst deasserts.
- Push:
  - A push occurs when fetch_val & fetch_rdy & !flush & fetch_cnt != 0.
  - Lane i < fetch_cnt is written to entry (tail_q+i) mod IQ_DEPTH, with pc = fetch_pc + 4*i (ADDR_LEN modular arithmetic).
  - tail advances by fetch_cnt.
  - fetch_val while fetch_rdy=0 is ignored; fetch holds the packet.
  - fetch_cnt > FETCH_WIDTH is illegal. The bench asserts on it.
- Dispatch (combinational from registered state):
  - avail = min(count_q, ISSUE_WIDTH_MAX).
  - instr_val_id[i] = !dispatch_stall & !flush & (i < avail).
  - instr_id[i] and pc_id[i] come from entry (head_q+i) mod IQ_DEPTH when the lane is valid, otherwise 0.
- Pop: at posedge, head advances by popcount(instr_val_id). Consumption is unconditional; rename takes every valid lane. Zero pop while stalled.
- Same-cycle push and pop:
  - count_next = count_q + pushed - popped.
  - Push uses the pre-pop tail and pop uses the pre-push head. No bypass: an instruction pushed at cycle N is first visible on instr_id at N+1.
- Flush has priority over push and pop. At posedge: head_q=tail_q=0, count_q=0, incoming packet dropped. instr_val_id is 0 in the flush cycle. rdy_q updates from count_next=0.
- Wrap-around: entries and PCs must stay in program order across the IQ_DEPTH boundary.
- count never exceeds IQ_DEPTH, which is guaranteed by the registered rdy_q check. The bench asserts count_q <= IQ_DEPTH and count_q >= 0.
- Reset mid-operation: immediate clear to reset state regardless of clk. No partial lane output.
- Latency: fetch packet to instr_val_id is 1 cycle minimum.

Test Plan:
- Reset then idle: rst low 3 cycles, release → fetch_rdy=0 until the first edge, then 1. instr_val_id=0, iq_count=0.
- Single push: fetch_cnt=4, pc=0x100, instrs A..D, no stall.
  - Next cycle: lanes {A@0x100, B@0x104}, val=2'b11.
  - Cycle after: {C@0x108, D@0x10C}.
  - Then val=0 and iq_count=0.
- Partial packet: fetch_cnt=3 at pc=0x200 → cycle 1 val=2'b11 (0x200, 0x204), cycle 2 val=2'b01 (0x208 on lane 0 only). Lane 1 instr_id and pc_id = 0.
- Stall/backpressure: dispatch_stall=1, push 4-instr packets every cycle.
  - iq_count goes 4, 8, 12, 16.
  - fetch_rdy drops to 0 once count=16 (after count reaches 13+), and further packets are not taken.
  - Release the stall → drain 2 per cycle in exact PC order. fetch_rdy reasserts when free >= 4.
- Wrap-around with concurrent push/pop: stream 40 sequential instructions from pc=0 with random stall → instr_id/pc_id match the scoreboard order 0, 4, 8, … with no gaps or duplicates across pointer wrap.
- Flush: count=10 with fetch_val=1 and flush=1 in the same cycle → instr_val_id=0 in that cycle. Next cycle iq_count=0, the packet is dropped and fetch_rdy=1. A subsequent push at pc=0x400 appears on lane 0 first.
